// File: rtl/icache_nway_pkg.sv
// Shared types and address field helpers for the N-way instruction cache.
// The slice macros expect BO_W, IDX_W and WORD_SIZE to be in scope at the point of use.
`define ICN_BO(a)  a[BO_W-1:0]
`define ICN_IDX(a) a[BO_W+IDX_W-1:BO_W]
`define ICN_TAG(a) a[WORD_SIZE-1:BO_W+IDX_W]

package icache_nway_pkg;

  typedef enum logic [1:0] {
    CHECK  = 2'd0,
    REFILL = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Field widths for a given geometry; the cache uses these for its localparams.
  function automatic int bo_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int tag_w(input int word_size, input int sets, input int block_words);
    return word_size - $clog2(sets) - $clog2(block_words);
  endfunction

endpackage

// File: rtl/icache_lru_set.sv
// True-LRU bookkeeping for one set: age update for an accessed way and victim choice.
// Ages form a permutation of 0..WAYS-1; age WAYS-1 is the least recently used way.
module icache_lru_set
  import icache_nway_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [AGE_W-1:0]           acc_way_i,
  output logic [WAYS-1:0][AGE_W-1:0] age_o,
  output logic [AGE_W-1:0]           victim_o
);

  logic [AGE_W-1:0] old_age;
  logic             found;

  always_comb begin
    old_age = age_i[acc_way_i];
    age_o   = age_i;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == acc_way_i) age_o[w] = '0;
      else if (age_i[w] < old_age) age_o[w] = age_i[w] + 1'b1;
    end
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o = AGE_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_i[w] == AGE_W'(WAYS-1)) victim_o = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with true-LRU replacement,
// critical-word forwarding on refill, multi-cycle flush and saturating counters.
module icache_nway
  import icache_nway_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int WAYS        = 2,
  parameter int SETS        = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_valid,
  input  logic [WORD_SIZE-1:0]             cpu_address,
  output logic [WORD_SIZE-1:0]             cpu_data,
  output logic                             cpu_inputReady,
  input  logic                             flush_req,
  output logic                             flush_done,
  output logic                             read_m,
  output logic [WORD_SIZE-1:0]             address,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] data,
  input  logic                             inputReady,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [CNT_W-1:0]                 miss_count
);

  localparam int BO_W   = bo_w(BLOCK_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(WORD_SIZE, SETS, BLOCK_WORDS);
  localparam int AGE_W  = age_w(WAYS);
  localparam int LINE_W = BLOCK_WORDS*WORD_SIZE;

  typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [AGE_W-1:0]     way;
  } miss_t;

  state_e                     state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d;
  ages_t [SETS-1:0]           age_q, age_d;
  miss_t                      miss_q, miss_d;
  logic                       flush_pend_q, flush_pend_d;
  logic [IDX_W-1:0]           flush_set_q, flush_set_d;
  logic [CNT_W-1:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0] data_mem [WAYS][SETS];

  logic [BO_W-1:0]   bo, rbo;
  logic [IDX_W-1:0]  idx, ridx;
  logic [TAG_W-1:0]  tag, rtag;
  logic [WAYS-1:0]   way_hit;
  logic              hit, fill_we;
  logic [AGE_W-1:0]  hit_way, lru_way;
  logic [LINE_W-1:0] hit_line;

  ages_t [SETS-1:0]             lru_new;
  logic [SETS-1:0][AGE_W-1:0]   lru_vic;

  assign bo   = `ICN_BO(cpu_address);
  assign idx  = `ICN_IDX(cpu_address);
  assign tag  = `ICN_TAG(cpu_address);
  assign rbo  = `ICN_BO(miss_q.addr);
  assign ridx = `ICN_IDX(miss_q.addr);
  assign rtag = `ICN_TAG(miss_q.addr);

  always_comb begin
    way_hit = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[idx][w] && (tag_mem[w][idx] == tag);
      if (way_hit[w]) hit_way = AGE_W'(w);
    end
  end

  assign hit      = |way_hit;
  assign hit_line = data_mem[hit_way][idx];
  assign lru_way  = (state_q == REFILL) ? miss_q.way : hit_way;

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    icache_lru_set #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
      .age_i    (age_q[s]),
      .valid_i  (valid_q[s]),
      .acc_way_i(lru_way),
      .age_o    (lru_new[s]),
      .victim_o (lru_vic[s])
    );
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    age_d          = age_q;
    miss_d         = miss_q;
    flush_pend_d   = flush_pend_q;
    flush_set_d    = flush_set_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    fill_we        = 1'b0;
    cpu_inputReady = 1'b0;
    cpu_data       = '0;
    flush_done     = 1'b0;
    case (state_q)
      CHECK: begin
        if (flush_req || flush_pend_q) begin
          state_d      = FLUSH;
          flush_set_d  = '0;
          flush_pend_d = 1'b0;
        end else if (cpu_valid) begin
          if (hit) begin
            cpu_inputReady = 1'b1;
            cpu_data       = hit_line[bo*WORD_SIZE +: WORD_SIZE];
            age_d[idx]     = lru_new[idx];
            hit_cnt_d      = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
          end else begin
            miss_d.addr = cpu_address;
            miss_d.way  = lru_vic[idx];
            miss_cnt_d  = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
            state_d     = REFILL;
          end
        end
      end
      REFILL: begin
        if (flush_req) flush_pend_d = 1'b1;
        if (inputReady) begin
          fill_we                    = 1'b1;
          valid_d[ridx][miss_q.way]  = 1'b1;
          age_d[ridx]                = lru_new[ridx];
          state_d                    = CHECK;
          // Forward the requested word straight from the bus; the array is written at the edge.
          if (cpu_valid && cpu_address == miss_q.addr) begin
            cpu_inputReady = 1'b1;
            cpu_data       = data[rbo*WORD_SIZE +: WORD_SIZE];
          end
        end
      end
      FLUSH: begin
        valid_d[flush_set_q] = '0;
        for (int w = 0; w < WAYS; w++) age_d[flush_set_q][w] = AGE_W'(w);
        flush_set_d = flush_set_q + 1'b1;
        if (flush_set_q == IDX_W'(SETS-1)) begin
          flush_done = 1'b1;
          state_d    = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CHECK;
      valid_q      <= '0;
      miss_q       <= '0;
      flush_pend_q <= 1'b0;
      flush_set_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      age_q        <= age_d;
      miss_q       <= miss_d;
      flush_pend_q <= flush_pend_d;
      flush_set_q  <= flush_set_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we && !reset) begin
      tag_mem[miss_q.way][ridx]  <= rtag;
      data_mem[miss_q.way][ridx] <= data;
    end
  end

  assign read_m     = (state_q == REFILL);
  assign address    = {miss_q.addr[WORD_SIZE-1:BO_W], {BO_W{1'b0}}};
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
